// File: rtl/multichannel_stream_fifo.sv
// N-channel ready/valid buffer: per-channel circular FIFOs merged round-robin onto one tagged output stream.
// Define MCSF_LEVEL_EN to add the per-channel fill-level output port.
module multichannel_stream_fifo #(
  parameter int NUM_CHANNELS = 4,
  parameter int WIDTH        = 24,
  parameter int DEPTH        = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_CHANNELS-1:0]            in_valid,
  output logic [NUM_CHANNELS-1:0]            in_ready,
  input  logic [NUM_CHANNELS*WIDTH-1:0]      in_data,
  input  logic [NUM_CHANNELS-1:0]            flush,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH-1:0]                   out_data,
  output logic [$clog2(NUM_CHANNELS)-1:0]    out_chan
`ifdef MCSF_LEVEL_EN
  ,
  output logic [NUM_CHANNELS*($clog2(DEPTH)+1)-1:0] level
`endif
);

  localparam int CW   = $clog2(NUM_CHANNELS);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0]                  mem [NUM_CHANNELS][DEPTH];
  logic [NUM_CHANNELS-1:0][AW-1:0]   wr_ptr;
  logic [NUM_CHANNELS-1:0][AW-1:0]   rd_ptr;
  logic [NUM_CHANNELS-1:0][CNTW-1:0] count;
  logic [NUM_CHANNELS-1:0]           push;
  logic [NUM_CHANNELS-1:0]           pop;
  logic [NUM_CHANNELS-1:0]           non_empty;
  logic [CW-1:0]                     last_grant;
  logic [CW-1:0]                     grant;
  logic [CW-1:0]                     cand;
  logic                              grant_valid;
  logic                              loadable;
  logic                              running;

  // Holds in_ready low until the first clock edge after reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) running <= 1'b0;
    else          running <= 1'b1;
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      in_ready[c]  = running && (count[c] != CNTW'(DEPTH)) && !flush[c];
      push[c]      = in_valid[c] && in_ready[c];
      non_empty[c] = (count[c] != '0) && !flush[c];
    end
  end

  assign loadable = !out_valid || out_ready;

  // Rotating priority starting just after the last granted channel.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    cand        = '0;
    pop         = '0;
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      cand = CW'((int'(last_grant) + i) % NUM_CHANNELS);
      if (!grant_valid && non_empty[cand]) begin
        grant_valid = 1'b1;
        grant       = cand;
      end
    end
    if (loadable && grant_valid) pop[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (flush[c]) begin
          wr_ptr[c] <= '0;
          rd_ptr[c] <= '0;
          count[c]  <= '0;
        end else begin
          if (push[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
          if (pop[c])  rd_ptr[c] <= rd_ptr[c] + AW'(1);
          count[c] <= count[c] + CNTW'(push[c]) - CNTW'(pop[c]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= in_data[c*WIDTH +: WIDTH];
    end
  end

  // A word already in the output register survives a flush of its source channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      last_grant <= CW'(NUM_CHANNELS - 1);
    end else if (loadable) begin
      if (grant_valid) begin
        out_valid  <= 1'b1;
        out_data   <= mem[grant][rd_ptr[grant]];
        out_chan   <= grant;
        last_grant <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MCSF_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: tb/tb_multichannel_stream_fifo.sv
// Self-checking bench for multichannel_stream_fifo: queue-based reference model compared every cycle,
// plus directed scenarios (reset, fairness, full, backpressure, flush, reset mid-transfer).
module tb_multichannel_stream_fifo;

  localparam int N    = 4;
  localparam int W    = 24;
  localparam int D    = 16;
  localparam int CW   = 2;
  localparam int CNTW = 5;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    flush;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [CW-1:0]   out_chan;
`ifdef MCSF_LEVEL_EN
  logic [N*CNTW-1:0] level;
`endif

  multichannel_stream_fifo #(.NUM_CHANNELS(N), .WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan)
`ifdef MCSF_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: one queue per channel plus the output word and round-robin pointer.
  logic [W-1:0] mq [N][$];
  logic         mvalid = 1'b0;
  logic [W-1:0] mdata  = '0;
  int           mchan  = 0;
  int           mlast  = N - 1;
  logic         mrun   = 1'b0;

  logic [W-1:0] del_data [$];
  int           del_chan [$];
  int           del_cyc  [$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < N; c++) mq[c].delete();
    mvalid = 1'b0;
    mdata  = '0;
    mchan  = 0;
    mlast  = N - 1;
    mrun   = 1'b0;
  endtask

  task automatic modelStep();
    logic [N-1:0] rdy;
    logic         ld;
    int           g;
    int           c;
    cyc++;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      del_data.push_back(out_data);
      del_chan.push_back(int'(out_chan));
      del_cyc.push_back(cyc);
    end
    for (int k = 0; k < N; k++) rdy[k] = mrun && (mq[k].size() < D) && !flush[k];
    ld = !mvalid || out_ready;
    g  = -1;
    for (int i = 1; i <= N; i++) begin
      c = (mlast + i) % N;
      if (g < 0 && mq[c].size() > 0 && !flush[c]) g = c;
    end
    if (ld) begin
      if (g >= 0) begin
        mdata  = mq[g].pop_front();
        mchan  = g;
        mvalid = 1'b1;
        mlast  = g;
      end else begin
        mvalid = 1'b0;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (flush[k]) mq[k].delete();
      else if (in_valid[k] && rdy[k]) mq[k].push_back(in_data[k*W +: W]);
    end
    mrun = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (reset_n !== 1'b1) modelReset();
      else modelStep();
    end
  end

  task automatic compareModel();
    logic [N-1:0] exp_rdy;
    for (int k = 0; k < N; k++) exp_rdy[k] = mrun && (mq[k].size() < D) && !flush[k];
    checkOutput("out_valid", 64'(out_valid), 64'(mvalid));
    if (mvalid) begin
      checkOutput("out_data", 64'(out_data), 64'(mdata));
      checkOutput("out_chan", 64'(out_chan), 64'(mchan));
    end
    checkOutput("in_ready", 64'(in_ready), 64'(exp_rdy));
`ifdef MCSF_LEVEL_EN
    for (int k = 0; k < N; k++) checkOutput("level", 64'(level[k*CNTW +: CNTW]), 64'(mq[k].size()));
`endif
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) compareModel();
  end

  function automatic logic [N*W-1:0] chanData(input int c, input logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = '0;
    r[c*W +: W] = v;
    return r;
  endfunction

  // Drive one cycle's worth of inputs, then advance to 2 time units past the next rising edge.
  task automatic applyStimulus(input logic [N-1:0] iv, input logic [N*W-1:0] id,
                               input logic [N-1:0] fl, input logic ordy);
    in_valid  = iv;
    in_data   = id;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    #2;
  endtask

  task automatic clearDeliveries();
    del_data.delete();
    del_chan.delete();
    del_cyc.delete();
  endtask

  initial begin
    logic [N*W-1:0] d;
    reset_n   = 1'b0;
    in_valid  = '1;
    in_data   = '0;
    flush     = '0;
    out_ready = 1'b0;

    // Reset with all write requests asserted
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    reset_n  = 1'b1;
    in_valid = '0;
    @(posedge clk);
    #2;
    checkOutput("release_in_ready", 64'(in_ready), 64'hF);

    // Fairness: three words per channel, then drain
    clearDeliveries();
    for (int k = 0; k < 3; k++) begin
      d = '0;
      for (int c = 0; c < N; c++) d[c*W +: W] = W'(32'hA00000 + 16*k + c);
      applyStimulus(4'hF, d, 4'h0, 1'b0);
    end
    for (int i = 0; i < 16; i++) applyStimulus(4'h0, '0, 4'h0, 1'b1);
    checkOutput("fair_count", 64'(del_data.size()), 64'd12);
    for (int j = 0; j < 12; j++) begin
      if (j < del_data.size()) begin
        checkOutput("fair_chan", 64'(del_chan[j]), 64'(j % 4));
        checkOutput("fair_data", 64'(del_data[j]), 64'(32'hA00000 + 16*(j/4) + (j%4)));
        checkOutput("fair_gap", 64'(del_cyc[j] - del_cyc[0]), 64'(j));
      end
    end

    // Full: park a ch0 word in the output register, then overfill ch1
    applyStimulus(4'h1, chanData(0, 24'hB00000), 4'h0, 1'b0);
    applyStimulus(4'h0, '0, 4'h0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(4'h2, chanData(1, W'(32'hC00000 + i)), 4'h0, 1'b0);
      checkOutput("full_in_ready1", 64'(in_ready[1]), 64'(i < 15));
`ifdef MCSF_LEVEL_EN
      if (i >= 15) checkOutput("full_level1", 64'(level[1*CNTW +: CNTW]), 64'd16);
`endif
    end
    clearDeliveries();
    applyStimulus(4'h0, '0, 4'h0, 1'b1);
    checkOutput("pop_in_ready1", 64'(in_ready[1]), 64'd1);
`ifdef MCSF_LEVEL_EN
    checkOutput("pop_level1", 64'(level[1*CNTW +: CNTW]), 64'd15);
`endif

    // Backpressure: output word must stay put for five stalled cycles
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'h0, '0, 4'h0, 1'b0);
      checkOutput("stall_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_data", 64'(out_data), 64'hC00000);
      checkOutput("stall_chan", 64'(out_chan), 64'd1);
`ifdef MCSF_LEVEL_EN
      checkOutput("stall_level1", 64'(level[1*CNTW +: CNTW]), 64'd15);
`endif
    end
    for (int i = 0; i < 20; i++) applyStimulus(4'h0, '0, 4'h0, 1'b1);
    checkOutput("full_drain_count", 64'(del_data.size()), 64'd17);
    if (del_data.size() > 0) begin
      checkOutput("full_drain_first", 64'(del_data[0]), 64'hB00000);
      checkOutput("full_drain_first_chan", 64'(del_chan[0]), 64'd0);
    end
    for (int j = 1; j < 17; j++) begin
      if (j < del_data.size()) begin
        checkOutput("full_drain_data", 64'(del_data[j]), 64'(32'hC00000 + j - 1));
        checkOutput("full_drain_chan", 64'(del_chan[j]), 64'd1);
      end
    end

    // Flush: ch2 holds five words, output register holds a sixth
    for (int i = 0; i < 6; i++) applyStimulus(4'h4, chanData(2, W'(32'hD00000 + i)), 4'h0, 1'b0);
    applyStimulus(4'h4, chanData(2, 24'hDEAD00), 4'h4, 1'b0);
    checkOutput("flush_held_data", 64'(out_data), 64'hD00000);
`ifdef MCSF_LEVEL_EN
    checkOutput("flush_level2", 64'(level[2*CNTW +: CNTW]), 64'd0);
`endif
    clearDeliveries();
    for (int i = 0; i < 6; i++) applyStimulus(4'h0, '0, 4'h0, 1'b1);
    checkOutput("flush_deliv_count", 64'(del_data.size()), 64'd1);
    if (del_data.size() > 0) begin
      checkOutput("flush_deliv_data", 64'(del_data[0]), 64'hD00000);
      checkOutput("flush_deliv_chan", 64'(del_chan[0]), 64'd2);
    end

    // Reset in the middle of traffic discards everything at once
    applyStimulus(4'h8, chanData(3, 24'hE00000), 4'h0, 1'b0);
    applyStimulus(4'h8, chanData(3, 24'hE00001), 4'h0, 1'b0);
    in_valid = '0;
    reset_n  = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    clearDeliveries();
    for (int i = 0; i < 4; i++) applyStimulus(4'h0, '0, 4'h0, 1'b1);
    checkOutput("midreset_deliv_count", 64'(del_data.size()), 64'd0);
    checkOutput("midreset_in_ready_after", 64'(in_ready), 64'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
